dc_launch_sequencer: RTL and testbench

//  Sequences DAC playback after the DC dispatcher has loaded channel frames. Tracks which

---
 rtl/dc_pkg.sv | 28 ++
 rtl/lseq_down_counter.sv | 25 ++
 rtl/dc_launch_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_dc_launch_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dc_pkg.sv
// Shared constants and types for the DC launch sequencer: opcodes, command word
// indices and the sequencer state encoding.
package dc_pkg;

   localparam int DAC_CHANNEL_DEFAULT = 24;
   localparam int MIN_PERIOD_DEFAULT  = 2;

   localparam logic [7:0] LSEQ_OP_START = 8'h01;
   localparam logic [7:0] LSEQ_OP_STOP  = 8'h02;

   localparam int LSEQ_W_CTRL   = 0;
   localparam int LSEQ_W_DELAY  = 1;
   localparam int LSEQ_W_REPEAT = 2;
   localparam int LSEQ_W_PERIOD = 3;

   typedef enum logic [1:0] {
      IDLE,
      DELAY,
      FIRE,
      PERIOD
   } lseq_state_t;

   // Word 0 sits in the low 32 bits of the flattened command bus.
   function automatic logic [31:0] lseq_word(input logic [127:0] cmd, input int idx);
      return cmd[idx*32 +: 32];
   endfunction

endpackage

// File: rtl/lseq_down_counter.sv
// 32-bit loadable down counter with zero flag; shared by the delay and period phases.
module lseq_down_counter (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        load_i,
   input  logic [31:0] load_val_i,
   input  logic        dec_i,
   output logic        zero_o
);

   logic [31:0] count_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else if (load_i) begin
         count_q <= load_val_i;
      end else if (dec_i && (count_q != 32'd0)) begin
         count_q <= count_q - 32'd1;
      end
   end

   assign zero_o = (count_q == 32'd0);

endmodule

// File: rtl/dc_launch_sequencer.sv
// Launch sequencer: tracks loaded DAC channel frames and emits timed trigger pulses.
// Optional LSEQ_PULSE_IDX_EN adds o_pulse_idx reporting the 0-based index of each pulse.
module dc_launch_sequencer
   import dc_pkg::*;
#(
   parameter int DAC_CHANNEL = DAC_CHANNEL_DEFAULT,
   parameter int MIN_PERIOD  = MIN_PERIOD_DEFAULT
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_valid_frame,
   input  logic [4:0]             i_channel_sel,
   input  logic [127:0]           i_launch_cmd,
   input  logic                   i_launch_valid,
   output logic [DAC_CHANNEL-1:0] o_trig,
   output logic [DAC_CHANNEL-1:0] o_ch_loaded,
   output logic                   o_busy,
   output logic                   o_done,
   output logic                   o_abort,
`ifdef LSEQ_PULSE_IDX_EN
   output logic [15:0]            o_pulse_idx,
`endif
   output logic                   o_cmd_err
);

   // The period phase needs at least two states (FIRE + PERIOD), so never go below 2.
   localparam logic [31:0] MIN_P = (MIN_PERIOD < 2) ? 32'd2 : 32'(MIN_PERIOD);
   localparam logic [5:0]  CH_LIMIT = 6'(DAC_CHANNEL);
   localparam logic [DAC_CHANNEL-1:0] ONE_HOT0 = {{(DAC_CHANNEL-1){1'b0}}, 1'b1};

   lseq_state_t state_q, state_d;

   logic                   launch_prev_q;
   logic [DAC_CHANNEL-1:0] loaded_q, loaded_d;
   logic [DAC_CHANNEL-1:0] active_q, active_d;
   logic [DAC_CHANNEL-1:0] refreshed_q, refreshed_d;
   logic [15:0]            repeat_q, repeat_d;
   logic [15:0]            pulse_cnt_q, pulse_cnt_d;
   logic [31:0]            period_ld_q, period_ld_d;
   logic                   done_q, done_d;
   logic                   abort_q, abort_d;
   logic                   err_q, err_d;

   logic                   cnt_load, cnt_dec, cnt_zero;
   logic [31:0]            cnt_val;

   logic [31:0]            w0, w1, w2, w3, period_eff;
   logic [7:0]             opcode;
   logic [DAC_CHANNEL-1:0] frame_bit, start_active;
   logic                   cmd_rise, is_start, is_stop, is_bad;
   logic                   unused_cmd_bits;

   assign w0 = lseq_word(i_launch_cmd, LSEQ_W_CTRL);
   assign w1 = lseq_word(i_launch_cmd, LSEQ_W_DELAY);
   assign w2 = lseq_word(i_launch_cmd, LSEQ_W_REPEAT);
   assign w3 = lseq_word(i_launch_cmd, LSEQ_W_PERIOD);
   assign unused_cmd_bits = ^{w0, w2[31:16]};

   assign opcode       = w0[31:24];
   assign cmd_rise     = i_launch_valid & ~launch_prev_q;
   assign is_start     = cmd_rise && (opcode == LSEQ_OP_START);
   assign is_stop      = cmd_rise && (opcode == LSEQ_OP_STOP);
   assign is_bad       = cmd_rise && !is_start && !is_stop;
   assign start_active = w0[DAC_CHANNEL-1:0] & loaded_q;
   assign period_eff   = (w3 < MIN_P) ? MIN_P : w3;
   assign frame_bit    = (i_valid_frame && ({1'b0, i_channel_sel} < CH_LIMIT)) ?
                         (ONE_HOT0 << i_channel_sel) : '0;

   lseq_down_counter u_cnt (
      .clk_i      (i_clk),
      .rst_ni     (i_rst),
      .load_i     (cnt_load),
      .load_val_i (cnt_val),
      .dec_i      (cnt_dec),
      .zero_o     (cnt_zero)
   );

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q       <= IDLE;
         launch_prev_q <= 1'b0;
         loaded_q      <= '0;
         active_q      <= '0;
         refreshed_q   <= '0;
         repeat_q      <= '0;
         pulse_cnt_q   <= '0;
         period_ld_q   <= '0;
         done_q        <= 1'b0;
         abort_q       <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         launch_prev_q <= i_launch_valid;
         loaded_q      <= loaded_d;
         active_q      <= active_d;
         refreshed_q   <= refreshed_d;
         repeat_q      <= repeat_d;
         pulse_cnt_q   <= pulse_cnt_d;
         period_ld_q   <= period_ld_d;
         done_q        <= done_d;
         abort_q       <= abort_d;
         err_q         <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      active_d    = active_q;
      repeat_d    = repeat_q;
      period_ld_d = period_ld_q;
      pulse_cnt_d = pulse_cnt_q;
      refreshed_d = refreshed_q | frame_bit;
      loaded_d    = loaded_q | frame_bit;
      done_d      = 1'b0;
      abort_d     = 1'b0;
      err_d       = is_bad;
      cnt_load    = 1'b0;
      cnt_val     = w1;
      cnt_dec     = 1'b0;

      case (state_q)
         IDLE: begin
            if (is_start) begin
               if (start_active == '0) begin
                  err_d = 1'b1;
               end else begin
                  state_d     = DELAY;
                  active_d    = start_active;
                  repeat_d    = w2[15:0];
                  period_ld_d = period_eff - 32'd2;
                  pulse_cnt_d = '0;
                  refreshed_d = frame_bit;
                  cnt_load    = 1'b1;
                  cnt_val     = w1;
               end
            end
         end
         DELAY, PERIOD: begin
            if (cnt_zero) state_d = FIRE;
            else          cnt_dec = 1'b1;
         end
         FIRE: begin
            pulse_cnt_d = pulse_cnt_q + 16'd1;
            // Channels refreshed during the run keep their loaded bit at completion.
            if ((repeat_q != 16'd0) && (pulse_cnt_d == repeat_q)) begin
               state_d  = IDLE;
               done_d   = 1'b1;
               loaded_d = (loaded_q & ~(active_q & ~refreshed_q)) | frame_bit;
            end else begin
               state_d  = PERIOD;
               cnt_load = 1'b1;
               cnt_val  = period_ld_q;
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_q != IDLE) begin
         if (is_start) err_d = 1'b1;
         if (is_stop) begin
            state_d  = IDLE;
            abort_d  = 1'b1;
            done_d   = 1'b0;
            loaded_d = loaded_q | frame_bit;
         end
      end
   end

`ifdef LSEQ_PULSE_IDX_EN
   logic [15:0] pulse_idx_q;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         pulse_idx_q <= '0;
      end else if (state_d == IDLE) begin
         pulse_idx_q <= '0;
      end else if ((state_d == FIRE) && (state_q != FIRE)) begin
         pulse_idx_q <= pulse_cnt_q;
      end
   end

   assign o_pulse_idx = pulse_idx_q;
`endif

   assign o_trig      = (state_q == FIRE) ? active_q : '0;
   assign o_ch_loaded = loaded_q;
   assign o_busy      = (state_q != IDLE);
   assign o_done      = done_q;
   assign o_abort     = abort_q;
   assign o_cmd_err   = err_q;

endmodule

// File: tb/tb_dc_launch_sequencer.sv
// Directed self-checking bench for dc_launch_sequencer (default 24 channels, MIN_PERIOD 2).
module tb_dc_launch_sequencer;
   import dc_pkg::*;

   logic         i_clk = 1'b0;
   logic         i_rst = 1'b0;
   logic         i_valid_frame = 1'b0;
   logic [4:0]   i_channel_sel = '0;
   logic [127:0] i_launch_cmd = '0;
   logic         i_launch_valid = 1'b0;
   logic [23:0]  o_trig, o_ch_loaded;
   logic         o_busy, o_done, o_abort, o_cmd_err;
`ifdef LSEQ_PULSE_IDX_EN
   logic [15:0]  o_pulse_idx;
`endif

   int total = 0;
   int bad   = 0;

   always #5 i_clk = ~i_clk;

   dc_launch_sequencer dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_valid_frame  (i_valid_frame),
      .i_channel_sel  (i_channel_sel),
      .i_launch_cmd   (i_launch_cmd),
      .i_launch_valid (i_launch_valid),
      .o_trig         (o_trig),
      .o_ch_loaded    (o_ch_loaded),
      .o_busy         (o_busy),
      .o_done         (o_done),
      .o_abort        (o_abort),
`ifdef LSEQ_PULSE_IDX_EN
      .o_pulse_idx    (o_pulse_idx),
`endif
      .o_cmd_err      (o_cmd_err)
   );

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic set_cmd(input logic [7:0] op, input logic [23:0] mask, input logic [31:0] d,
                          input logic [15:0] n, input logic [31:0] p);
      i_launch_cmd = {p, 16'h0000, n, d, op, mask};
   endtask

   task automatic load_frame(input logic [4:0] ch);
      i_valid_frame = 1'b1;
      i_channel_sel = ch;
      tick();
      i_valid_frame = 1'b0;
   endtask

   task automatic test_reset();
      tick();
      tick();
      total++;
      if ({o_trig, o_ch_loaded, o_busy, o_done, o_abort, o_cmd_err} !== 52'd0) begin
         bad++;
         $display("[TB] FAIL reset_outputs got=%h exp=0",
                  {o_trig, o_ch_loaded, o_busy, o_done, o_abort, o_cmd_err});
      end
      i_rst = 1'b1;
      tick();
      load_frame(5'd24);
      load_frame(5'd30);
      tick();
      total++;
      if (o_ch_loaded !== 24'h0) begin
         bad++;
         $display("[TB] FAIL out_of_range_frame got=%h exp=000000", o_ch_loaded);
      end
   endtask

   task automatic test_basic_run();
      logic [23:0] et;
      load_frame(5'd3);
      total++;
      if (o_ch_loaded !== 24'h8) begin
         bad++;
         $display("[TB] FAIL basic_loaded got=%h exp=000008", o_ch_loaded);
      end
      set_cmd(LSEQ_OP_START, 24'h8, 32'd5, 16'd3, 32'd10);
      i_launch_valid = 1'b1;
      for (int k = 0; k <= 30; k++) begin
         tick();
         if (k == 0) i_launch_valid = 1'b0;
         et = (k == 6 || k == 16 || k == 26) ? 24'h8 : 24'h0;
         total++;
         if (o_trig !== et) begin
            bad++;
            $display("[TB] FAIL basic_trig k=%0d got=%h exp=%h", k, o_trig, et);
         end
         total++;
         if (o_done !== 1'(k == 27)) begin
            bad++;
            $display("[TB] FAIL basic_done k=%0d got=%b exp=%b", k, o_done, k == 27);
         end
         total++;
         if (o_busy !== 1'(k <= 26)) begin
            bad++;
            $display("[TB] FAIL basic_busy k=%0d got=%b exp=%b", k, o_busy, k <= 26);
         end
      end
      total++;
      if (o_ch_loaded !== 24'h0) begin
         bad++;
         $display("[TB] FAIL basic_consumed got=%h exp=000000", o_ch_loaded);
      end
   endtask

   task automatic test_cmd_err();
      set_cmd(LSEQ_OP_START, 24'h10, 32'd0, 16'd1, 32'd2);
      i_launch_valid = 1'b1;
      for (int k = 0; k <= 4; k++) begin
         tick();
         if (k == 0) i_launch_valid = 1'b0;
         total++;
         if (o_cmd_err !== 1'(k == 0)) begin
            bad++;
            $display("[TB] FAIL unloaded_err k=%0d got=%b exp=%b", k, o_cmd_err, k == 0);
         end
         total++;
         if (o_busy !== 1'b0 || o_trig !== 24'h0) begin
            bad++;
            $display("[TB] FAIL unloaded_idle k=%0d busy=%b trig=%h exp busy=0 trig=0",
                     k, o_busy, o_trig);
         end
      end
      set_cmd(LSEQ_OP_STOP, 24'h0, 32'd0, 16'd0, 32'd0);
      i_launch_valid = 1'b1;
      for (int k = 0; k <= 2; k++) begin
         tick();
         if (k == 0) i_launch_valid = 1'b0;
         total++;
         if ({o_cmd_err, o_abort, o_busy} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL stop_idle k=%0d got=%b exp=000", k, {o_cmd_err, o_abort, o_busy});
         end
      end
   endtask

   task automatic test_stop_continuous();
      logic [23:0] et;
      load_frame(5'd1);
      set_cmd(LSEQ_OP_START, 24'h2, 32'd0, 16'd0, 32'd2);
      i_launch_valid = 1'b1;
      for (int k = 0; k <= 20; k++) begin
         tick();
         if (k == 0) i_launch_valid = 1'b0;
         et = (k >= 1 && k <= 13 && (k % 2) == 1) ? 24'h2 : 24'h0;
         total++;
         if (o_trig !== et) begin
            bad++;
            $display("[TB] FAIL stop_trig k=%0d got=%h exp=%h", k, o_trig, et);
         end
         total++;
         if (o_abort !== 1'(k == 15) || o_done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL stop_abort k=%0d abort=%b done=%b exp abort=%b done=0",
                     k, o_abort, o_done, k == 15);
         end
         total++;
         if (o_busy !== 1'(k <= 14)) begin
            bad++;
            $display("[TB] FAIL stop_busy k=%0d got=%b exp=%b", k, o_busy, k <= 14);
         end
         if (k == 14) begin
            set_cmd(LSEQ_OP_STOP, 24'h0, 32'd0, 16'd0, 32'd0);
            i_launch_valid = 1'b1;
         end
         if (k == 15) i_launch_valid = 1'b0;
      end
      total++;
      if (o_ch_loaded !== 24'h2) begin
         bad++;
         $display("[TB] FAIL stop_loaded_kept got=%h exp=000002", o_ch_loaded);
      end
   endtask

   task automatic test_err_during_run();
      logic [23:0] et;
      set_cmd(LSEQ_OP_START, 24'h2, 32'd2, 16'd4, 32'd4);
      i_launch_valid = 1'b1;
      for (int k = 0; k <= 20; k++) begin
         tick();
         if (k == 0) i_launch_valid = 1'b0;
         et = (k == 3 || k == 7 || k == 11 || k == 15) ? 24'h2 : 24'h0;
         total++;
         if (o_trig !== et) begin
            bad++;
            $display("[TB] FAIL busy_err_trig k=%0d got=%h exp=%h", k, o_trig, et);
         end
         total++;
         if (o_cmd_err !== 1'(k == 5 || k == 9)) begin
            bad++;
            $display("[TB] FAIL busy_err_flag k=%0d got=%b exp=%b", k, o_cmd_err, k == 5 || k == 9);
         end
         total++;
         if (o_done !== 1'(k == 16)) begin
            bad++;
            $display("[TB] FAIL busy_err_done k=%0d got=%b exp=%b", k, o_done, k == 16);
         end
         if (k == 4) begin
            set_cmd(LSEQ_OP_START, 24'h2, 32'd0, 16'd1, 32'd2);
            i_launch_valid = 1'b1;
         end
         if (k == 8) begin
            set_cmd(8'h7F, 24'h2, 32'd0, 16'd1, 32'd2);
            i_launch_valid = 1'b1;
         end
         if (k == 5 || k == 9) i_launch_valid = 1'b0;
      end
      total++;
      if (o_ch_loaded !== 24'h0) begin
         bad++;
         $display("[TB] FAIL busy_err_loaded got=%h exp=000000", o_ch_loaded);
      end
   endtask

   task automatic test_min_period();
      logic [23:0] et;
      load_frame(5'd0);
      set_cmd(LSEQ_OP_START, 24'h1, 32'd1, 16'd3, 32'd0);
      i_launch_valid = 1'b1;
      for (int k = 0; k <= 22; k++) begin
         tick();
         et = (k == 2 || k == 4 || k == 6) ? 24'h1 : 24'h0;
         total++;
         if (o_trig !== et) begin
            bad++;
            $display("[TB] FAIL p0_trig k=%0d got=%h exp=%h", k, o_trig, et);
         end
         total++;
         if (o_done !== 1'(k == 7) || o_busy !== 1'(k <= 6) || o_cmd_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL p0_status k=%0d done=%b busy=%b err=%b exp done=%b busy=%b err=0",
                     k, o_done, o_busy, o_cmd_err, k == 7, k <= 6);
         end
         if (k == 3) begin
            i_valid_frame = 1'b1;
            i_channel_sel = 5'd0;
         end
         if (k == 4) i_valid_frame = 1'b0;
      end
      i_launch_valid = 1'b0;
      total++;
      if (o_ch_loaded !== 24'h1) begin
         bad++;
         $display("[TB] FAIL p0_refreshed got=%h exp=000001", o_ch_loaded);
      end
      tick();
      set_cmd(LSEQ_OP_START, 24'h1, 32'd0, 16'd2, 32'd1);
      i_launch_valid = 1'b1;
      for (int k = 0; k <= 8; k++) begin
         tick();
         if (k == 0) i_launch_valid = 1'b0;
         et = (k == 1 || k == 3) ? 24'h1 : 24'h0;
         total++;
         if (o_trig !== et) begin
            bad++;
            $display("[TB] FAIL p1_trig k=%0d got=%h exp=%h", k, o_trig, et);
         end
         total++;
         if (o_done !== 1'(k == 4)) begin
            bad++;
            $display("[TB] FAIL p1_done k=%0d got=%b exp=%b", k, o_done, k == 4);
         end
      end
      total++;
      if (o_ch_loaded !== 24'h0) begin
         bad++;
         $display("[TB] FAIL p1_loaded got=%h exp=000000", o_ch_loaded);
      end
   endtask

   task automatic test_refresh_and_reset();
      logic [23:0] et;
      load_frame(5'd3);
      load_frame(5'd5);
      set_cmd(LSEQ_OP_START, 24'h28, 32'd0, 16'd2, 32'd3);
      i_launch_valid = 1'b1;
      for (int k = 0; k <= 8; k++) begin
         tick();
         if (k == 0) i_launch_valid = 1'b0;
         et = (k == 1 || k == 4) ? 24'h28 : 24'h0;
         total++;
         if (o_trig !== et) begin
            bad++;
            $display("[TB] FAIL refresh_trig k=%0d got=%h exp=%h", k, o_trig, et);
         end
         total++;
         if (o_done !== 1'(k == 5)) begin
            bad++;
            $display("[TB] FAIL refresh_done k=%0d got=%b exp=%b", k, o_done, k == 5);
         end
         if (k == 2 || k == 4) begin
            i_valid_frame = 1'b1;
            i_channel_sel = (k == 2) ? 5'd3 : 5'd5;
         end
         if (k == 3 || k == 5) i_valid_frame = 1'b0;
      end
      total++;
      if (o_ch_loaded !== 24'h28) begin
         bad++;
         $display("[TB] FAIL refresh_loaded got=%h exp=000028", o_ch_loaded);
      end
      set_cmd(LSEQ_OP_START, 24'h8, 32'd20, 16'd1, 32'd2);
      i_launch_valid = 1'b1;
      for (int k = 0; k <= 5; k++) begin
         tick();
         if (k == 0) i_launch_valid = 1'b0;
         total++;
         if (o_busy !== 1'b1 || o_trig !== 24'h0) begin
            bad++;
            $display("[TB] FAIL delay_busy k=%0d busy=%b trig=%h exp busy=1 trig=0", k, o_busy, o_trig);
         end
      end
      #2;
      i_rst = 1'b0;
      #1;
      total++;
      if ({o_trig, o_ch_loaded, o_busy, o_done, o_abort, o_cmd_err} !== 52'd0) begin
         bad++;
         $display("[TB] FAIL async_reset got=%h exp=0",
                  {o_trig, o_ch_loaded, o_busy, o_done, o_abort, o_cmd_err});
      end
      tick();
      i_rst = 1'b1;
      for (int k = 0; k <= 25; k++) begin
         tick();
         total++;
         if (o_busy !== 1'b0 || o_trig !== 24'h0) begin
            bad++;
            $display("[TB] FAIL post_reset k=%0d busy=%b trig=%h exp busy=0 trig=0", k, o_busy, o_trig);
         end
      end
   endtask

   initial begin
      $display("[TB] dc_launch_sequencer directed test start");
      test_reset();
      test_basic_run();
      test_cmd_err();
      test_stop_continuous();
      test_err_during_run();
      test_min_period();
      test_refresh_and_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
